// File: rtl/vt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vt_pkg
// Description : Shared types and elaboration-time helpers for the
//               Varshamov-Tenengolts encoder and its companion blocks.
//               - is_pow2         : position is a parity slot (1, 2, 4, ...)
//               - vt_parity_count : number of parity slots for length n
//               - vt_msg_len      : number of message bits for length n
//               - vt_enc_state_t  : encoder FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package vt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_PARITY = 2'd2,
        ST_HOLD   = 2'd3
    } vt_enc_state_t;

    function automatic logic is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // floor(log2 n) + 1, i.e. the bit length of n.
    function automatic int vt_parity_count(input int n);
        int p;
        p = 0;
        for (int v = n; v > 0; v = v >> 1) begin
            p++;
        end
        return p;
    endfunction

    function automatic int vt_msg_len(input int n);
        return n - vt_parity_count(n);
    endfunction

endpackage : vt_pkg
`default_nettype wire

// File: rtl/vt_mod_accum.sv
`default_nettype none
// ============================================================================
// Module      : vt_mod_accum
// Description : Registered modulo-M accumulator with synchronous clear.
//               sum <= (sum + add_val) mod M when add_en is high.
//               add_val must be below M so one conditional subtract suffices.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset (sum -> 0)
//               clr     - synchronous clear, has priority over add_en
//               add_en  - accumulate add_val this cycle
//               add_val - addend, 0 .. M-1
//               sum     - registered running sum, 0 .. M-1
// Revision    : 1.0 - initial release
// ============================================================================
module vt_mod_accum #(
    parameter int M = 11,
    parameter int W = $clog2(M)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         add_en,
    input  logic [W-1:0] add_val,
    output logic [W-1:0] sum
);

    // One extra bit holds sum + add_val, which is at most 2M-2.
    logic [W:0]   raw;
    logic [W-1:0] wrapped;

    assign raw = {1'b0, sum} + {1'b0, add_val};

    always_comb begin
        wrapped = W'(raw);
        if (raw >= (W + 1)'(M)) begin
            wrapped = W'(raw - (W + 1)'(M));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= wrapped;
        end
    end

endmodule : vt_mod_accum
`default_nettype wire

// File: rtl/vt_encoder.sv
`default_nettype none
// ============================================================================
// Module      : vt_encoder
// Description : Sequential Varshamov-Tenengolts encoder. Places K message
//               bits on the non-power-of-two positions of an N-bit codeword,
//               one position per cycle, accumulating sum(i*x_i) mod (N+1),
//               then fills the power-of-two positions with the binary digits
//               of d = (A - s) mod (N+1) so the codeword checksum equals A.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               msg_valid - msg carries a message
//               msg       - K message bits, msg[0] -> lowest data position
//               msg_ready - encoder idle, message will be accepted
//               strand    - codeword, x_i on strand[i-1], upper bits zero
//               cw_valid  - strand holds a valid codeword
//               cw_ready  - downstream accepts the codeword
// Revision    : 1.0 - initial release
// ============================================================================
module vt_encoder
    import vt_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int N          = 10,
    parameter  int A          = 0,
    localparam int K          = vt_msg_len(N),
    localparam int P          = vt_parity_count(N),
    localparam int SW         = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msg_valid,
    input  logic [K-1:0]          msg,
    output logic                  msg_ready,
    output logic [DATA_WIDTH-1:0] strand,
    output logic                  cw_valid,
    input  logic                  cw_ready
);

    generate
        if (A < 0 || A > N) begin : g_bad_syndrome
            $error("vt_encoder: syndrome A=%0d outside 0..N=%0d", A, N);
        end
        if (DATA_WIDTH < N) begin : g_bad_width
            $error("vt_encoder: DATA_WIDTH=%0d smaller than N=%0d", DATA_WIDTH, N);
        end
    endgenerate

    vt_enc_state_t state;
    vt_enc_state_t state_nxt;

    logic [SW-1:0] pos;       // current codeword position i (1..N)
    logic [K-1:0]  msg_sh;    // unused message bits, next one at bit 0
    logic [N-1:0]  cw;        // codeword shifted in from the top, x_1 ends at bit 0
    logic [SW-1:0] s;         // running checksum mod N+1
    logic [SW-1:0] d;         // parity value (A - s) mod N+1
    logic [N-1:0]  cw_par;    // codeword with parity slots filled

    logic accept;
    logic pos_pow2;
    logic x_bit;
    logic add_en;

    assign accept   = (state == ST_IDLE) && msg_valid && msg_ready;
    assign pos_pow2 = is_pow2(int'(pos));
    assign x_bit    = pos_pow2 ? 1'b0 : msg_sh[0];
    assign add_en   = (state == ST_ACCUM) && x_bit;

    vt_mod_accum #(
        .M (N + 1),
        .W (SW)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .add_en  (add_en),
        .add_val (pos),
        .sum     (s)
    );

    // Arithmetic wraps mod 2^SW; the true result is always in 0..N, which
    // fits in SW bits, so any intermediate overflow cancels out.
    always_comb begin
        d = SW'(A) - s;
        if (s > SW'(A)) begin
            d = SW'(A) + SW'(N + 1) - s;
        end
    end

    // Parity slots in cw are zero after accumulation, so overwrite them.
    always_comb begin
        cw_par = cw;
        for (int j = 0; j < P; j++) begin
            cw_par[(1 << j) - 1] = d[j];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (pos == SW'(N)) begin
                    state_nxt = ST_PARITY;
                end
            end
            ST_PARITY: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (cw_valid && cw_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos       <= '0;
            msg_sh    <= '0;
            cw        <= '0;
            strand    <= '0;
            cw_valid  <= 1'b0;
            msg_ready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        msg_sh    <= msg;
                        cw        <= '0;
                        pos       <= SW'(1);
                        msg_ready <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    cw <= {x_bit, cw[N-1:1]};
                    if (!pos_pow2) begin
                        msg_sh <= msg_sh >> 1;
                    end
                    // Stop at N so the counter never wraps when N+1 = 2^SW.
                    if (pos != SW'(N)) begin
                        pos <= pos + SW'(1);
                    end
                end
                ST_PARITY: begin
                    strand   <= DATA_WIDTH'(cw_par);
                    cw_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (cw_valid && cw_ready) begin
                        cw_valid  <= 1'b0;
                        msg_ready <= 1'b1;
                        pos       <= '0;
                    end
                end
                default: begin
                    cw_valid  <= 1'b0;
                    msg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule : vt_encoder
`default_nettype wire

// File: tb/tb_vt_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vt_encoder
// Description : Directed self-checking bench for vt_encoder (n=10). One
//               instance uses a=0, a second uses a=5; a select line steers
//               the shared stimulus to one of them at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vt_encoder;

    logic        clk;
    logic        rst_n;
    logic        msg_valid;
    logic [5:0]  msg;
    logic        cw_ready;
    logic        sel;

    logic        msg_ready0, cw_valid0, msg_ready5, cw_valid5;
    logic [31:0] strand0, strand5;
    logic        msg_valid0, msg_valid5;

    logic        obs_ready, obs_valid;
    logic [31:0] obs_strand;

    int n_checks;
    int n_fail;

    assign msg_valid0 = msg_valid & ~sel;
    assign msg_valid5 = msg_valid & sel;
    assign obs_ready  = sel ? msg_ready5 : msg_ready0;
    assign obs_valid  = sel ? cw_valid5  : cw_valid0;
    assign obs_strand = sel ? strand5    : strand0;

    vt_encoder #(.DATA_WIDTH(32), .N(10), .A(0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_valid (msg_valid0),
        .msg       (msg),
        .msg_ready (msg_ready0),
        .strand    (strand0),
        .cw_valid  (cw_valid0),
        .cw_ready  (cw_ready)
    );

    vt_encoder #(.DATA_WIDTH(32), .N(10), .A(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_valid (msg_valid5),
        .msg       (msg),
        .msg_ready (msg_ready5),
        .strand    (strand5),
        .cw_valid  (cw_valid5),
        .cw_ready  (cw_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference codeword for n=10 built from the VT definition.
    function automatic logic [31:0] vt_ref(input logic [5:0] m, input int a);
        logic [31:0] c;
        int s, idx, dd;
        c = '0;
        s = 0;
        idx = 0;
        for (int i = 1; i <= 10; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (m[idx]) begin
                    c[i-1] = 1'b1;
                    s += i;
                end
                idx++;
            end
        end
        dd = ((a - (s % 11)) % 11 + 11) % 11;
        for (int j = 0; j < 4; j++) begin
            if (dd[j]) c[(1 << j) - 1] = 1'b1;
        end
        return c;
    endfunction

    function automatic int checksum(input logic [31:0] c);
        int t;
        t = 0;
        for (int i = 1; i <= 10; i++) begin
            if (c[i-1]) t += i;
        end
        return t % 11;
    endfunction

    // Accept a message, wait for the codeword, check latency and value.
    // With cw_ready high, also checks the handshake returns to idle.
    task automatic encode(input string tag, input logic [5:0] m, input logic [31:0] exp);
        int cyc;
        @(negedge clk);
        msg       = m;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        chk({tag, "_ready_low"}, 32'(obs_ready), 32'd0);
        cyc = 0;
        while (!obs_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd11);
        chk({tag, "_strand"}, obs_strand, exp);
        if (cw_ready) begin
            @(posedge clk); #1;
            chk({tag, "_valid_clr"}, 32'(obs_valid), 32'd0);
            chk({tag, "_ready_back"}, 32'(obs_ready), 32'd1);
        end
    endtask

    initial begin
        int cyc;
        int base;
        logic [5:0] m;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        msg_valid = 1'b0;
        msg       = '0;
        cw_ready  = 1'b1;
        sel       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_msg_ready", 32'(msg_ready0), 32'd1);
        chk("rst_cw_valid", 32'(cw_valid0), 32'd0);
        chk("rst_strand", strand0, 32'h0);
        chk("rst_msg_ready_a5", 32'(msg_ready5), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, a=0
        encode("zero", 6'b000000, 32'h000);
        encode("one", 6'b000001, 32'h084);
        encode("all", 6'b111111, 32'h37C);

        // a=5 instance
        sel = 1'b1;
        encode("a5_zero", 6'b000000, 32'h009);
        encode("a5_one", 6'b000001, 32'h006);
        sel = 1'b0;

        // Back-pressure: cw_ready low, stray msg_valid pulses ignored
        cw_ready = 1'b0;
        @(negedge clk);
        msg       = 6'b100000;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        cyc = 0;
        while (!cw_valid0 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) begin
                msg       = 6'b111111;
                msg_valid = 1'b1;
            end else if (cyc == 4) begin
                msg_valid = 1'b0;
            end
        end
        chk("stall_latency", 32'(cyc), 32'd11);
        chk("stall_strand0", strand0, 32'h201);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                msg       = 6'b010101;
                msg_valid = 1'b1;
            end else if (k == 2) begin
                msg_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("stall_strand_%0d", k), strand0, 32'h201);
            chk($sformatf("stall_valid_%0d", k), 32'(cw_valid0), 32'd1);
            chk($sformatf("stall_ready_%0d", k), 32'(msg_ready0), 32'd0);
        end
        cw_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_valid_clr", 32'(cw_valid0), 32'd0);
        chk("stall_ready_back", 32'(msg_ready0), 32'd1);
        chk("stall_strand_kept", strand0, 32'h201);

        // Reset in the middle of accumulation
        encode("pre_rst", 6'b111111, 32'h37C);
        @(negedge clk);
        msg       = 6'b000001;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(cw_valid0), 32'd0);
        chk("midrst_strand", strand0, 32'h0);
        chk("midrst_ready", 32'(msg_ready0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_no_cw", 32'(cw_valid0), 32'd0);
        encode("post_rst", 6'b000001, 32'h084);

        // Sweep all 64 messages in a shuffled order
        base = int'($urandom_range(0, 63));
        for (int k = 0; k < 64; k++) begin
            m = 6'((k * 37 + base) & 63);
            encode($sformatf("sweep_%0d", m), m, vt_ref(m, 0));
            chk($sformatf("sweep_sum_%0d", m), 32'(checksum(strand0)), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vt_encoder
`default_nettype wire
